// File: rtl/toggle_event_rx_pkg.sv
// Shared defaults and helpers for the toggle-event receiver and the transmitter-side benches.
package toggle_event_rx_pkg;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_PEND_W      = 4;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_TIMEOUT     = 100;
  localparam int DEF_PEND_MAX    = (2 ** DEF_PEND_W) - 1;

  typedef enum logic [1:0] {
    PEND_HOLD,
    PEND_INC,
    PEND_DEC,
    PEND_DROP
  } pend_op_e;

  function automatic int timer_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

  // A detect and an accept in the same cycle cancel, so a full queue never drops then.
  function automatic pend_op_e pend_op(input logic det, input logic acc, input logic full);
    if (det && !acc) return full ? PEND_DROP : PEND_INC;
    if (!det && acc) return PEND_DEC;
    return PEND_HOLD;
  endfunction

endpackage

// File: rtl/toggle_sync_detect.sv
// Synchronises the toggle line and emits a registered one-cycle pulse per level change.
module toggle_sync_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic tog_in,
  output logic tog_det
);

  logic sync_out;
  logic prev_q, prev_d;
  logic det_q, det_d;
  logic [SYNC_STAGES:0] arm_q, arm_d;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign sync_out = tog_in;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    always_comb sync_d = (sync_q << 1) | SYNC_STAGES'(tog_in);
    always_ff @(posedge clk) begin
      if (!rstn) sync_q <= '0;
      else       sync_q <= sync_d;
    end
    assign sync_out = sync_q[SYNC_STAGES-1];
  end

  // The chain restarts at 0 after reset, so detection is held off until prev
  // has been loaded with a value that really came through the synchroniser.
  always_comb begin
    arm_d  = (arm_q << 1) | {{SYNC_STAGES{1'b0}}, 1'b1};
    prev_d = sync_out;
    det_d  = arm_q[SYNC_STAGES] & (sync_out != prev_q);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      arm_q  <= '0;
      prev_q <= 1'b0;
      det_q  <= 1'b0;
    end else begin
      arm_q  <= arm_d;
      prev_q <= prev_d;
      det_q  <= det_d;
    end
  end

  assign tog_det = det_q;

endmodule

// File: rtl/toggle_event_rx.sv
// Toggle-link receiver: queues detected events and hands them out over valid/ready,
// with total count, sticky overflow and idle timeout.
module toggle_event_rx
  import toggle_event_rx_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int PEND_W      = DEF_PEND_W,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              tog_in,
  output logic              evt_valid,
  input  logic              evt_ready,
  input  logic              clr_ovf,
  output logic [PEND_W-1:0] pend_cnt,
  output logic [CNT_W-1:0]  total_cnt,
  output logic              overflow,
  output logic              idle
);

  localparam int                TMR_W    = timer_width(TIMEOUT);
  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
  localparam logic [TMR_W-1:0]  TMR_LIM  = TMR_W'(TIMEOUT);

  function automatic logic [TMR_W-1:0] timer_sat_inc(input logic [TMR_W-1:0] v);
    return (v == TMR_LIM) ? v : v + TMR_W'(1);
  endfunction

  logic              tog_det;
  logic              acc;
  pend_op_e          op;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic [CNT_W-1:0]  total_q, total_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              ovf_q, ovf_d;
  logic              idle_q, idle_d;

  toggle_sync_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_detect (
    .clk    (clk),
    .rstn   (rstn),
    .tog_in (tog_in),
    .tog_det(tog_det)
  );

  always_comb begin
    acc     = (pend_q != '0) & evt_ready;
    op      = pend_op(tog_det, acc, pend_q == PEND_MAX);
    pend_d  = pend_q;
    case (op)
      PEND_INC: pend_d = pend_q + PEND_W'(1);
      PEND_DEC: pend_d = pend_q - PEND_W'(1);
      default:  pend_d = pend_q;
    endcase
    // A drop in the same cycle as clr_ovf keeps the flag set.
    ovf_d   = (op == PEND_DROP) | (ovf_q & ~clr_ovf);
    total_d = total_q + CNT_W'(tog_det);
    if (tog_det) begin
      timer_d = '0;
      idle_d  = 1'b0;
    end else begin
      timer_d = timer_sat_inc(timer_q);
      idle_d  = (timer_d == TMR_LIM);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pend_q  <= '0;
      total_q <= '0;
      timer_q <= '0;
      ovf_q   <= 1'b0;
      idle_q  <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      total_q <= total_d;
      timer_q <= timer_d;
      ovf_q   <= ovf_d;
      idle_q  <= idle_d;
    end
  end

  assign evt_valid = (pend_q != '0);
  assign pend_cnt  = pend_q;
  assign total_cnt = total_q;
  assign overflow  = ovf_q;
  assign idle      = idle_q;

endmodule
